// File: rtl/r2p_pkg.sv
// Digit encoding and per-digit helpers shared by the r2p_mult signed-digit multiplier.
// Digits are 2-bit two's complement: 01=+1, 00=0, 11=-1; code 10 is illegal and reads as 0.
package r2p_pkg;

  localparam int D = 2;

  typedef logic [D-1:0] sd_t;

  localparam sd_t SD_POS  = 2'b01;
  localparam sd_t SD_ZERO = 2'b00;
  localparam sd_t SD_NEG  = 2'b11;

  function automatic sd_t sd_clean(input sd_t c);
    sd_t r;
    case (c)
      SD_POS:  r = SD_POS;
      SD_NEG:  r = SD_NEG;
      default: r = SD_ZERO;
    endcase
    return r;
  endfunction

  function automatic sd_t sd_neg(input sd_t c);
    sd_t r;
    case (c)
      SD_POS:  r = SD_NEG;
      SD_NEG:  r = SD_POS;
      default: r = SD_ZERO;
    endcase
    return r;
  endfunction

  // Signed value of a digit, widened so that two digits can be summed without overflow.
  function automatic logic signed [D:0] sd_dec(input sd_t c);
    logic signed [D:0] r;
    case (c)
      SD_POS:  r = 3'sb001;
      SD_NEG:  r = 3'sb111;
      default: r = 3'sb000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/r2p_sd_add.sv
// Carry-free radix-2 signed-digit adder: two N-digit SD vectors in, one (N+1)-digit SD vector out.
// Each position looks only one digit down, so the delay does not depend on N.
module r2p_sd_add import r2p_pkg::*; #(
  parameter int N = 8
) (
  input  logic [D*N-1:0]     a_i,
  input  logic [D*N-1:0]     b_i,
  output logic [D*(N+1)-1:0] s_o
);

  logic [2:0] z_s   [N];
  logic [2:0] sum_s [N];
  logic [N:0] nn_s;
  sd_t        tr_s  [N+1];
  sd_t        im_s  [N];

  // nn_s[i]: both digits at position i-1 are non-negative, which bounds the incoming transfer to {0,+1}.
  always_comb begin
    nn_s    = '0;
    nn_s[0] = 1'b1;
    tr_s    = '{default: SD_ZERO};
    im_s    = '{default: SD_ZERO};
    s_o     = '0;
    for (int i = 0; i < N; i++) begin
      nn_s[i+1] = (a_i[D*i +: D] != SD_NEG) && (b_i[D*i +: D] != SD_NEG);
    end
    for (int i = 0; i < N; i++) begin
      z_s[i] = sd_dec(a_i[D*i +: D]) + sd_dec(b_i[D*i +: D]);
      case (z_s[i])
        3'b010: begin tr_s[i+1] = SD_POS; im_s[i] = SD_ZERO; end
        3'b110: begin tr_s[i+1] = SD_NEG; im_s[i] = SD_ZERO; end
        3'b001: begin
          if (nn_s[i]) begin tr_s[i+1] = SD_POS;  im_s[i] = SD_NEG; end
          else         begin tr_s[i+1] = SD_ZERO; im_s[i] = SD_POS; end
        end
        3'b111: begin
          if (nn_s[i]) begin tr_s[i+1] = SD_ZERO; im_s[i] = SD_NEG; end
          else         begin tr_s[i+1] = SD_NEG;  im_s[i] = SD_POS; end
        end
        default: begin tr_s[i+1] = SD_ZERO; im_s[i] = SD_ZERO; end
      endcase
    end
    for (int i = 0; i < N; i++) begin
      sum_s[i]         = sd_dec(im_s[i]) + sd_dec(tr_s[i]);
      s_o[D*i +: D]    = sum_s[i][1:0];
    end
    s_o[D*N +: D] = tr_s[N];
  end

endmodule

// File: rtl/r2p_mult.sv
// Radix-2 signed-digit multiplier: parallel partial products reduced by a tree of r2p_sd_add, registered output.
// Define R2P_MULT_PIPE_EN to insert a register stage mid-tree (latency 2 instead of 1).
module r2p_mult import r2p_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] x,
  input  logic [2*WIDTH-1:0] y,
  output logic [4*WIDTH+1:0] p,
  output logic               out_valid
);

  localparam int NW     = 2*WIDTH + 1;
  localparam int LOG    = $clog2(WIDTH);
  localparam int LEAVES = 1 << LOG;
  localparam int PD     = LOG / 2;

  typedef logic [D*NW-1:0]     vec_t;
  typedef logic [D*(NW+1)-1:0] wide_t;

  vec_t  node_s [1:2*LEAVES-1];
  wide_t sum_s  [1:LEAVES-1];
  vec_t  p_d;
  logic  vld_d;

  function automatic vec_t pp_gen(input sd_t xd, input logic [2*WIDTH-1:0] yv, input int sh);
    vec_t pp;
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (xd)
        SD_POS:  pp[D*(i+sh) +: D] = sd_clean(yv[D*i +: D]);
        SD_NEG:  pp[D*(i+sh) +: D] = sd_neg(yv[D*i +: D]);
        default: pp[D*(i+sh) +: D] = SD_ZERO;
      endcase
    end
    return pp;
  endfunction

  // Any partial sum is bounded by (2^WIDTH-1)^2 < 2^(NW-1), so 2*top+next always lands in {-1,0,+1}.
  function automatic vec_t fold(input wide_t s);
    vec_t r;
    r = s[D*NW-1:0];
    if (s[D*NW +: D] != SD_ZERO) r[D*(NW-1) +: D] = s[D*NW +: D];
    else                         r[D*(NW-1) +: D] = s[D*(NW-1) +: D];
    return r;
  endfunction

  for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < WIDTH) begin : g_pp
      assign node_s[LEAVES+j] = pp_gen(x[D*j +: D], y, j);
    end else begin : g_pad
      assign node_s[LEAVES+j] = '0;
    end
  end

  for (genvar k = 1; k < LEAVES; k++) begin : g_tree
    r2p_sd_add #(.N(NW)) u_add (
      .a_i (node_s[2*k]),
      .b_i (node_s[2*k+1]),
      .s_o (sum_s[k])
    );
`ifdef R2P_MULT_PIPE_EN
    if (k >= (1 << PD) && k < (2 << PD)) begin : g_stage
      vec_t stage_q;
      // Mid-tree pipeline register splitting the leaf-side levels from the root-side levels.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= fold(sum_s[k]);
      end
      assign node_s[k] = stage_q;
    end else begin : g_comb
      assign node_s[k] = fold(sum_s[k]);
    end
`else
    assign node_s[k] = fold(sum_s[k]);
`endif
  end

`ifdef R2P_MULT_PIPE_EN
  logic vld_q;
  // First stage of the valid shift register, aligned with the mid-tree stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= in_valid;
  end
  assign vld_d = vld_q;
`else
  assign vld_d = in_valid;
`endif

  assign p_d = node_s[1];

  // Output register: p follows the operands every cycle; out_valid qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      p         <= p_d;
      out_valid <= vld_d;
    end
  end

endmodule

// File: tb/tb_r2p_mult.sv
// Self-checking bench for r2p_mult: directed table, randomized stream against an arithmetic model, async reset.
module tb_r2p_mult;

  localparam int W  = 32;
  localparam int ND = 2*W + 1;
`ifdef R2P_MULT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [2*W-1:0]   x;
  logic [2*W-1:0]   y;
  logic [4*W+1:0]   p;
  logic             out_valid;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic signed [127:0] val;
    logic                vld;
  } hist_t;
  hist_t hist[$];

  typedef struct {
    logic [2*W-1:0]      xv;
    logic [2*W-1:0]      yv;
    logic signed [127:0] exp;
    string               name;
  } vec_rec_t;
  vec_rec_t vecs[6];

  r2p_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .p         (p),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Value of an SD vector: sum of digit * 2^i, digit code 10 counts as 0.
  function automatic logic signed [127:0] sd_value(input logic [4*W+1:0] v, input int nd);
    logic signed [127:0] acc;
    acc = '0;
    for (int i = nd - 1; i >= 0; i--) begin
      acc = acc * 128'sd2;
      case (v[2*i +: 2])
        2'b01:   acc = acc + 128'sd1;
        2'b11:   acc = acc - 128'sd1;
        default: acc = acc;
      endcase
    end
    return acc;
  endfunction

  function automatic int count_bad(input logic [4*W+1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < ND; i++) if (v[2*i +: 2] == 2'b10) n++;
    return n;
  endfunction

  function automatic logic [2*W-1:0] rand_sd();
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case ($urandom_range(0, 2))
        0:       r[2*i +: 2] = 2'b00;
        1:       r[2*i +: 2] = 2'b01;
        default: r[2*i +: 2] = 2'b11;
      endcase
    end
    return r;
  endfunction

  function automatic logic signed [127:0] ref_mul(input logic [2*W-1:0] xv, input logic [2*W-1:0] yv);
    logic [4*W+1:0] xw;
    logic [4*W+1:0] yw;
    xw = {{(2*W+2){1'b0}}, xv};
    yw = {{(2*W+2){1'b0}}, yv};
    return sd_value(xw, W) * sd_value(yw, W);
  endfunction

  task automatic check(input string name, input logic signed [127:0] exp_val, input logic exp_vld);
    logic signed [127:0] got;
    int bad;
    got = sd_value(p, ND);
    bad = count_bad(p);
    n_chk++;
    if (got !== exp_val) begin
      n_fail++;
      $display("FAIL %s value: got %0d expected %0d", name, got, exp_val);
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s digits: %0d digits with code 10, expected 0", name, bad);
    end
    n_chk++;
    if (out_valid !== exp_vld) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b expected %b", name, out_valid, exp_vld);
    end
  endtask

  // Apply one operand set across a rising edge and record what it should produce.
  task automatic drive_edge(input logic [2*W-1:0] xv, input logic [2*W-1:0] yv, input logic v);
    hist_t e;
    x        = xv;
    y        = yv;
    in_valid = v;
    e.val    = ref_mul(xv, yv);
    e.vld    = v;
    hist.push_back(e);
    if (hist.size() > 8) void'(hist.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_check(input string name);
    hist_t e;
    int idx;
    idx = hist.size() - LAT;
    if (idx >= 0) e = hist[idx];
    else begin
      e.val = '0;
      e.vld = 1'b0;
    end
    check(name, e.val, e.vld);
  endtask

  initial begin
    logic signed [127:0] pmax;
    int lat;
    pmax = 128'sd18446744065119617025;

    vecs[0] = '{xv: '0,                    yv: rand_sd(),            exp: 128'sd0,       name: "zero"};
    vecs[1] = '{xv: 64'h1,                 yv: 64'h5555555555555555, exp: 128'sd4294967295, name: "unit"};
    vecs[2] = '{xv: 64'hFFFFFFFFFFFFFFFF,  yv: 64'h5555555555555555, exp: -pmax,         name: "ext_neg"};
    vecs[3] = '{xv: 64'hFFFFFFFFFFFFFFFF,  yv: 64'hFFFFFFFFFFFFFFFF, exp: pmax,          name: "ext_pos"};
    vecs[4] = '{xv: 64'h2,                 yv: rand_sd(),            exp: 128'sd0,       name: "illegal"};
    vecs[5] = '{xv: 64'h5555555555555555,  yv: 64'hFFFFFFFFFFFFFFFF, exp: -pmax,         name: "ext_neg2"};

    rst      = 1'b1;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    #1;
    check("reset", 128'sd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      drive_edge(vecs[k].xv, vecs[k].yv, 1'b1);
      for (int s = 1; s < LAT; s++) drive_edge('0, '0, 1'b0);
      check(vecs[k].name, vecs[k].exp, 1'b1);
    end
    drive_edge('0, '0, 1'b0);
    check("idle", 128'sd0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      drive_edge(rand_sd(), rand_sd(), $urandom_range(0, 3) != 0);
      model_check("random");
    end

    // Asynchronous reset between edges with a valid operand pair on the inputs.
    x        = 64'hFFFFFFFFFFFFFFFF;
    y        = 64'h5555555555555555;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 128'sd0, 1'b0);
    hist.delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", 128'sd0, 1'b0);
    rst = 1'b0;

    drive_edge(rand_sd(), rand_sd(), 1'b1);
    lat = 1;
    model_check("post_reset_first");
    while (out_valid !== 1'b1 && lat < 8) begin
      drive_edge('0, '0, 1'b0);
      lat++;
    end
    n_chk++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL reset_latency: got %0d cycles expected %0d", lat, LAT);
    end
    model_check("post_reset_result");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
